// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch_unit (master) and imem (slave).
`timescale 1ns/1ps
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus and feeds FI_ID.
// Optional FETCH_ALIGN_CHK_EN adds sticky misalign_o and word-aligns redirect targets.
`timescale 1ns/1ps
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    fetch_unit_if.master      imem,
    output logic [32:0]       pc_o,
    output logic [32:0]       inst_o,
    output logic              valid_o
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] addr_reg;
    logic        gap_reg, gap_next;
    logic [31:0] skid_pc_reg, skid_inst_reg;
    logic [31:0] out_pc_reg, out_inst_reg;
    logic        out_valid_reg;
    logic        req_active, ack, skid_load;
    logic        load_fetch, load_skid, load_bubble;
    logic [31:0] br_pc;

`ifdef FETCH_ALIGN_CHK_EN
    logic misalign_reg;
    assign br_pc      = {br_target[31:2], 2'b00};
    assign misalign_o = misalign_reg;
`else
    assign br_pc = br_target;
`endif

    // gap_reg idles the bus for one cycle after every ack, so each request is a fresh rise.
    assign req_active     = ((state_reg == REQ) && !gap_reg) || (state_reg == DROP);
    assign ack            = imem.imem_ack && req_active;
    assign imem.imem_req  = req_active;
    assign imem.imem_addr = !req_active ? 32'h0 : ((state_reg == DROP) ? addr_reg : pc_reg);

    assign pc_o    = {1'b0, out_pc_reg};
    assign inst_o  = {1'b0, out_inst_reg};
    assign valid_o = out_valid_reg;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        gap_next    = 1'b0;
        skid_load   = 1'b0;
        load_fetch  = 1'b0;
        load_skid   = 1'b0;
        load_bubble = !pause || br_taken;
        case (state_reg)
            BOOT: begin
                state_next = REQ;
                if (br_taken) pc_next = br_pc;
            end
            REQ: begin
                if (br_taken) begin
                    pc_next = br_pc;
                    if (ack) begin
                        gap_next = 1'b1;
                    end else if (req_active) begin
                        state_next = DROP;
                    end
                    // A redirect during the idle gap has nothing outstanding to drop.
                end else if (ack) begin
                    pc_next  = pc_reg + STEP;
                    gap_next = 1'b1;
                    if (pause) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        load_fetch  = 1'b1;
                        load_bubble = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_next    = br_pc;
                    state_next = REQ;
                end else if (!pause) begin
                    load_skid   = 1'b1;
                    load_bubble = 1'b0;
                    state_next  = REQ;
                end
            end
            DROP: begin
                if (br_taken) pc_next = br_pc;
                if (ack) begin
                    state_next = REQ;
                    gap_next   = 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            addr_reg      <= 32'h0;
            gap_reg       <= 1'b0;
            skid_pc_reg   <= 32'h0;
            skid_inst_reg <= 32'h0;
            out_pc_reg    <= 32'h0;
            out_inst_reg  <= 32'h0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            gap_reg   <= gap_next;
            // Remembers the in-flight address so DROP can keep presenting it after pc moves.
            if (state_reg == REQ) addr_reg <= pc_reg;
            if (skid_load) begin
                skid_pc_reg   <= pc_reg;
                skid_inst_reg <= imem.imem_rdata;
            end
            if (load_fetch) begin
                out_pc_reg    <= pc_reg;
                out_inst_reg  <= imem.imem_rdata;
                out_valid_reg <= 1'b1;
            end else if (load_skid) begin
                out_pc_reg    <= skid_pc_reg;
                out_inst_reg  <= skid_inst_reg;
                out_valid_reg <= 1'b1;
            end else if (load_bubble) begin
                out_pc_reg    <= 32'h0;
                out_inst_reg  <= 32'h0;
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_reg <= 1'b0;
        end else if (br_taken && (br_target[1:0] != 2'b00)) begin
            misalign_reg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected deliveries, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [32:0] pc_o, inst_o;
    logic        valid_o;
`ifdef FETCH_ALIGN_CHK_EN
    logic        misalign_o;
`endif

    fetch_unit_if imem_bus();

    fetch_unit #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem      (imem_bus),
        .pc_o      (pc_o),
        .inst_o    (inst_o),
        .valid_o   (valid_o)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic        pause_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: check bus at the negedge, then drive inputs for the next posedge.
    task automatic cyc(input logic er, input logic [31:0] ea, input logic ack,
                       input logic pz, input logic br, input logic [31:0] tgt, input logic push);
        @(negedge clk);
        chk("imem_req", {63'h0, imem_bus.imem_req}, {63'h0, er});
        if (er) chk("imem_addr", {32'h0, imem_bus.imem_addr}, {32'h0, ea});
        imem_bus.imem_ack   = ack;
        imem_bus.imem_rdata = ack ? (32'hC0DE_0000 ^ ea) : 32'hDEAD_BEEF;
        pause     = pz;
        br_taken  = br;
        br_target = tgt;
        if (ack) $display("ack   addr=%h br=%0b pause=%0b keep=%0b", ea, br, pz, push);
        if (push) sb_q.push_back({ea, 32'hC0DE_0000 ^ ea});
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(1'b1, a, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    always @(posedge clk) pause_q <= pause;

    // Monitor: a valid output loaded on an unpaused edge is a new delivery.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_o && !pause_q) begin
                $display("deliver pc=%h inst=%h", pc_o, inst_o);
                if (sb_q.size() == 0) begin
                    chk("unexpected_delivery", {31'h0, pc_o}, 64'h0);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    chk("deliver_pc", {31'h0, pc_o}, {32'h0, e[63:32]});
                    chk("deliver_inst", {31'h0, inst_o}, {32'h0, e[31:0]});
                end
            end else if (!valid_o) begin
                chk("bubble", {pc_o[31:0], inst_o[31:0]} | {63'h0, pc_o[32] | inst_o[32]}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", {63'h0, imem_bus.imem_req}, 64'h0);
        chk("rst_addr", {32'h0, imem_bus.imem_addr}, 64'h0);
        chk("rst_valid", {63'h0, valid_o}, 64'h0);
        chk("rst_pc", {31'h0, pc_o}, 64'h0);
        chk("rst_inst", {31'h0, inst_o}, 64'h0);
        rst = 1'b1;

        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        // Ack delayed three cycles: address must stay put.
        repeat (3) cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h10);
        fetch(32'h14); fetch(32'h18); fetch(32'h1C);
        // Pause on the ack cycle, held three edges.
        cyc(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h24);
        for (int a = 32'h28; a <= 32'h3C; a += 4) fetch(32'(a));
        // Redirect while 0x40 is outstanding.
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h100);
        // Redirect coinciding with ack.
        cyc(1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h200);
        // Second redirect while dropping overwrites the target.
        cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        cyc(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'h400);
        // PC wrap at the top of the address space.
        cyc(1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b1, 32'h404, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        fetch(32'hFFFF_FFFC);
        fetch(32'h0);
        // Redirect under pause while holding a skid word: skid is discarded.
        cyc(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0);
        fetch(32'h500);
`ifdef FETCH_ALIGN_CHK_EN
        cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
        cyc(1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("misalign_set", {63'h0, misalign_o}, 64'h1);
`else
        cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`endif
        // Reset with a request outstanding drops imem_req at once.
        rst = 1'b0;
        #1;
        chk("midreq_rst_req", {63'h0, imem_bus.imem_req}, 64'h0);
        chk("midreq_rst_addr", {32'h0, imem_bus.imem_addr}, 64'h0);
        chk("midreq_rst_valid", {63'h0, valid_o}, 64'h0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("misalign_clr", {63'h0, misalign_o}, 64'h0);
`endif
        imem_bus.imem_ack = 1'b0;
        br_taken = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
